icache_fetch: RTL
=================

ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 SHALL have parameter INDEX_W, default 7, meaning log2 of direct-mapped entry count (128 entries of one 32-bit word each).
REQ-002 SHALL have port clk_in  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy_in  input  1  global enable; when 0 all state holds.
REQ-005 SHALL have port fetch_req  input  1  fetch stage requests the instruction at fetch_pc.
REQ-006 SHALL have port fetch_pc  input  32  word-aligned fetch address; bits [1:0] ignored.
REQ-007 SHALL have port flush  input  1  abort the outstanding fetch (branch redirect).
REQ-008 SHALL have port fetch_done  output  1  one-cycle pulse, fetch_inst valid.
REQ-009 SHALL have port fetch_inst  output  32  fetched instruction, held until the next fetch_done.
REQ-010 SHALL have port if_pc_get  output  1  miss request to the memory controller.
REQ-011 SHALL have port if_pc_address  output  32  miss address to the memory controller.
REQ-012 SHALL have port if_done  input  1  memory controller one-cycle completion pulse.
REQ-013 SHALL have port if_out  input  32  little-endian word from the memory controller, valid with if_done.

Function
REQ-014 SHALL split fetch_pc as index = fetch_pc[INDEX_W+1:2], tag = fetch_pc[31:INDEX_W+2]; each entry holds valid bit, tag, 32-bit data.
REQ-015 SHALL implement states IDLE and MISS; reset state IDLE.
REQ-016 SHALL, in IDLE with rdy_in=1, fetch_req=1, flush=0, fetch_done=0, on hit (valid and tag match): register fetch_inst<=entry data, fetch_done<=1 next cycle, stay IDLE (hit latency 1 cycle).
REQ-017 SHALL, in the same IDLE condition on miss: latch fetch_pc into an internal miss address register, go to MISS; no fetch_done.
REQ-018 SHALL ignore fetch_req in any cycle where fetch_done=1 (upstream sees done and updates pc); peak hit throughput one per 2 cycles.
REQ-019 SHALL drive if_pc_get combinationally = (state==MISS) and (if_done==0), so it is already low in the cycle if_done is high and the controller never starts a spurious fetch.
REQ-020 SHALL drive if_pc_address = miss address register, constant for the whole MISS state (the controller aborts if the address changes mid-transfer); 0 in IDLE.
REQ-021 SHALL, in MISS with rdy_in=1, if_done=1, flush=0: write valid=1, tag, data=if_out into the indexed entry (overwriting), register fetch_inst<=if_out, fetch_done<=1, go IDLE.
REQ-022 SHALL, on flush=1 with rdy_in=1 in any state: go IDLE, fetch_done<=0, no cache write, fetch_req ignored that cycle; if_done arriving in the same cycle is discarded.
REQ-023 SHALL require upstream to hold fetch_req and fetch_pc stable from request until fetch_done or flush; behaviour otherwise undefined.
REQ-024 SHALL pulse fetch_done for exactly one rdy_in=1 cycle; fetch_done<=0 on every other enabled cycle.
REQ-025 SHALL, when rdy_in=0, hold state, all registers and cache contents unchanged; if_pc_get keeps its combinational definition.
REQ-026 SHALL never write the cache except per REQ-021.

Reset
REQ-027 SHALL, on rst_in=1 (regardless of rdy_in), clear all valid bits, state<=IDLE, fetch_done<=0, fetch_inst<=0, miss address<=0; thus if_pc_get=0, if_pc_address=0 in the following cycle.
REQ-028 SHALL abandon any in-progress miss on reset with no cache write.

Verification
REQ-029 SHALL cover cold miss: reset, fetch_pc=0x00000000 -> if_pc_get=1, if_pc_address=0; model returns if_out=0x00500093 -> fetch_done pulse 1 cycle later, fetch_inst=0x00500093.
REQ-030 SHALL cover hit: refetch 0x00000000 -> fetch_done exactly 1 cycle after request, if_pc_get stays 0.
REQ-031 SHALL cover conflict: fetch 0x00000200 (same index 0, tag 1) -> miss, entry replaced; then 0x00000000 -> miss again.
REQ-032 SHALL cover flush mid-miss: flush at 2nd MISS cycle -> if_pc_get 0 next cycle, no fetch_done, later fetch of same pc misses.
REQ-033 SHALL cover if_done and flush in the same cycle -> no fetch_done, no cache write.
REQ-034 SHALL cover rdy_in=0 for 5 cycles during MISS with if_done held -> completion delayed until rdy_in=1, single fetch_done, correct data.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-entry instruction cache in front of the fetch stage.
// Hits return one cycle after the request; misses are forwarded to the memory controller.
module icache_fetch #(
    parameter int INDEX_W = 7
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        fetch_done,
    output logic [31:0] fetch_inst,
    output logic        if_pc_get,
    output logic [31:0] if_pc_address,
    input  logic        if_done,
    input  logic [31:0] if_out
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = 30 - INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                done_q, done_d;
    logic [31:0]         inst_q, inst_d;
    logic [31:0]         miss_addr_q, miss_addr_d;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_mem  [ENTRIES];
    logic [31:0]         data_mem [ENTRIES];

    logic [INDEX_W-1:0]  req_idx, miss_idx;
    logic [TAG_W-1:0]    req_tag, miss_tag;
    logic                hit;
    logic                cache_we;

    assign req_idx  = fetch_pc[INDEX_W+1:2];
    assign req_tag  = fetch_pc[31:INDEX_W+2];
    assign miss_idx = miss_addr_q[INDEX_W+1:2];
    assign miss_tag = miss_addr_q[31:INDEX_W+2];
    assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        inst_d      = inst_q;
        miss_addr_d = miss_addr_q;
        cache_we    = 1'b0;
        if (rdy_in) begin
            done_d = 1'b0;
            if (flush) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        // A done cycle is the upstream's cue to move on, so its request is stale.
                        if (fetch_req && !done_q) begin
                            if (hit) begin
                                inst_d = data_mem[req_idx];
                                done_d = 1'b1;
                            end else begin
                                miss_addr_d = fetch_pc;
                                state_d     = MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (if_done) begin
                            cache_we = !rst_in;
                            inst_d   = if_out;
                            done_d   = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            inst_q      <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            inst_q      <= inst_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone decide hits.
    always_ff @(posedge clk_in) begin
        if (cache_we) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= if_out;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    valid_q[gi] <= 1'b0;
                end else if (cache_we && (miss_idx == INDEX_W'(gi))) begin
                    valid_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign fetch_done    = done_q;
    assign fetch_inst    = inst_q;
    assign if_pc_get     = (state_q == MISS) && !if_done;
    assign if_pc_address = (state_q == MISS) ? miss_addr_q : 32'd0;

endmodule
